branch_sequencer: RTL and testbench

Hardwired control-step sequencer for Mini SRC conditional branches (brzr/brnz/brpl/brmi), driving the datapath's bus strobes through fetch (T0–T2) and execute (T3–T6). Generalises the hand-scripted single-condition branch sequence: all four conditions, parametrised widths and opcode, a memory-ready handshake with timeout, and an optional early exit when the branch is not taken. Sits beside the datapath; consumes IR and bus contents, emits the strobes the datapath already accepts.

---
 rtl/branch_sequencer_if.sv | 50 +++++
 rtl/branch_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_branch_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Control/datapath boundary of the branch sequencer. The sequencer consumes
// IR, bus contents and memory handshake, and emits the datapath strobes plus
// status pulses.
interface branch_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  // datapath / control-unit side -> sequencer
  logic                  start;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] bus_data;

  // sequencer -> datapath strobes
  logic pc_out;
  logic mar_in;
  logic inc_pc;
  logic z_in;
  logic zlow_out;
  logic pc_in;
  logic read;
  logic mdr_in;
  logic mdr_out;
  logic ir_in;
  logic gra;
  logic rout;
  logic y_in;
  logic c_out;
  logic [4:0] alu_op;

  // sequencer status
  logic con_q;
  logic busy;
  logic done;
  logic illegal;
  logic timeout;

  modport master (
    output start, mem_ready, ir, bus_data,
    input  pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
           mdr_out, ir_in, gra, rout, y_in, c_out, alu_op,
           con_q, busy, done, illegal, timeout
  );

  modport slave (
    input  start, mem_ready, ir, bus_data,
    output pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in,
           mdr_out, ir_in, gra, rout, y_in, c_out, alu_op,
           con_q, busy, done, illegal, timeout
  );
endinterface

// File: rtl/branch_sequencer.sv
// Hardwired control-step sequencer for Mini SRC conditional branches
// (brzr/brnz/brpl/brmi). Walks fetch T0-T2 and execute T3-T6, with a
// bounded memory-ready wait in T1 and optional early exit on not-taken.
module branch_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] BR_OPCODE  = 5'b10011,
  parameter logic [4:0] ALU_ADD    = 5'b00011,
  parameter bit         EARLY_EXIT = 1'b0,
  parameter int         WAIT_LIMIT = 15
) (
  input  logic               clk,
  input  logic               clr,
  branch_sequencer_if.slave  seq
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    T6   = 3'd7
  } state_t;

  localparam int          CW      = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  // last wait cycle index: reaching it without mem_ready means timeout
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic          con_r, con_nx;

  logic [4:0] op;
  logic [1:0] c2;
  logic       is_br;
  logic       cond;

  logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, read, mdr_in;
  logic mdr_out, ir_in, gra, rout, y_in, c_out;
  logic [4:0] alu_op;
  logic done, illegal, timeout;

  // IR bits outside opcode and condition field are not part of the decode
  logic unused_ir;
  assign unused_ir = ^{seq.ir[DATA_WIDTH-6:21], seq.ir[18:0]};

  // instruction decode and branch condition, evaluated on the live bus
  always_comb begin
    op    = seq.ir[DATA_WIDTH-1 -: 5];
    c2    = seq.ir[20:19];
    is_br = (op == BR_OPCODE);
    cond  = 1'b0;
    case (c2)
      2'b00:   cond = (seq.bus_data == '0);            // brzr
      2'b01:   cond = (seq.bus_data != '0);            // brnz
      2'b10:   cond = ~seq.bus_data[DATA_WIDTH-1];     // brpl, zero counts as plus
      default: cond =  seq.bus_data[DATA_WIDTH-1];     // brmi
    endcase
  end

  // state, wait counter and latched condition
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      wait_cnt <= '0;
      con_r    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      con_r    <= con_nx;
    end
  end

  // next-state and strobe decode; strobes are Moore, pulses may use decode
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    con_nx   = con_r;
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    read     = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    gra      = 1'b0;
    rout     = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_op   = 5'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (seq.start) state_nx = T0;
      end
      T0: begin
        pc_out   = 1'b1;
        mar_in   = 1'b1;
        inc_pc   = 1'b1;
        z_in     = 1'b1;
        wait_nx  = '0;           // fresh wait budget for this fetch
        state_nx = T1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        if (seq.mem_ready) begin
          state_nx = T2;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_nx = wait_cnt + CW'(1);
        end
      end
      T2: begin
        mdr_out  = 1'b1;
        ir_in    = 1'b1;
        state_nx = T3;
      end
      T3: begin
        gra  = 1'b1;
        rout = 1'b1;
        if (!is_br) begin
          illegal  = 1'b1;       // con_q deliberately left alone
          state_nx = IDLE;
        end else begin
          con_nx = cond;
          if (EARLY_EXIT && !cond) begin
            done     = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = T4;
          end
        end
      end
      T4: begin
        pc_out   = 1'b1;
        y_in     = 1'b1;
        state_nx = T5;
      end
      T5: begin
        c_out    = 1'b1;
        z_in     = 1'b1;
        alu_op   = ALU_ADD;
        state_nx = T6;
      end
      T6: begin
        zlow_out = 1'b1;
        pc_in    = con_r;        // only load the target when taken
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign seq.pc_out   = pc_out;
  assign seq.mar_in   = mar_in;
  assign seq.inc_pc   = inc_pc;
  assign seq.z_in     = z_in;
  assign seq.zlow_out = zlow_out;
  assign seq.pc_in    = pc_in;
  assign seq.read     = read;
  assign seq.mdr_in   = mdr_in;
  assign seq.mdr_out  = mdr_out;
  assign seq.ir_in    = ir_in;
  assign seq.gra      = gra;
  assign seq.rout     = rout;
  assign seq.y_in     = y_in;
  assign seq.c_out    = c_out;
  assign seq.alu_op   = alu_op;
  assign seq.con_q    = con_r;
  assign seq.busy     = (state != IDLE);
  assign seq.done     = done;
  assign seq.illegal  = illegal;
  assign seq.timeout  = timeout;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: two instances (full sequence with
// WAIT_LIMIT=15, early-exit with WAIT_LIMIT=4) share inputs; only one is
// started per transaction. Expected outcomes come from a transaction-level
// model and are consumed by an independent monitor.
module tb_branch_sequencer;
  localparam int         DW  = 32;
  localparam logic [4:0] BR  = 5'b10011;
  localparam logic [4:0] ADD = 5'b00011;
  localparam int         WL0 = 15;
  localparam int         WL1 = 4;

  typedef enum int {K_DONE = 0, K_ILL = 1, K_TO = 2, K_ABORT = 3} kind_t;
  typedef struct {
    kind_t kind;
    int    lat;
    logic  pc;
    int    alu;
    logic  con;
    int    sel;
  } exp_t;
  typedef struct {
    logic [13:0] strb;
    logic [4:0]  alu;
    logic        con, busy, done, ill, to, pc_in;
  } snap_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic mem_ready = 1'b0;
  logic [DW-1:0] ir = '0;
  logic [DW-1:0] bus = '0;
  int sel = 0;

  int errors = 0;
  int checks = 0;
  exp_t q[$];
  logic con_m[2];
  logic [31:0] pool[6];

  always #5 clk = ~clk;

  branch_sequencer_if #(.DATA_WIDTH(DW)) if0 ();
  branch_sequencer_if #(.DATA_WIDTH(DW)) if1 ();

  assign if0.start     = start && (sel == 0);
  assign if1.start     = start && (sel == 1);
  assign if0.mem_ready = mem_ready;
  assign if1.mem_ready = mem_ready;
  assign if0.ir        = ir;
  assign if1.ir        = ir;
  assign if0.bus_data  = bus;
  assign if1.bus_data  = bus;

  branch_sequencer #(.DATA_WIDTH(DW), .BR_OPCODE(BR), .ALU_ADD(ADD),
                     .EARLY_EXIT(1'b0), .WAIT_LIMIT(WL0))
    dut0 (.clk(clk), .clr(clr), .seq(if0));
  branch_sequencer #(.DATA_WIDTH(DW), .BR_OPCODE(BR), .ALU_ADD(ADD),
                     .EARLY_EXIT(1'b1), .WAIT_LIMIT(WL1))
    dut1 (.clk(clk), .clr(clr), .seq(if1));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, x, $time);
    end
  endtask

  function automatic snap_t get(input int s);
    snap_t r;
    if (s == 0) begin
      r.strb = {if0.pc_out, if0.mar_in, if0.inc_pc, if0.z_in, if0.zlow_out, if0.pc_in, if0.read,
                if0.mdr_in, if0.mdr_out, if0.ir_in, if0.gra, if0.rout, if0.y_in, if0.c_out};
      r.alu = if0.alu_op; r.con = if0.con_q; r.busy = if0.busy; r.pc_in = if0.pc_in;
      r.done = if0.done; r.ill = if0.illegal; r.to = if0.timeout;
    end else begin
      r.strb = {if1.pc_out, if1.mar_in, if1.inc_pc, if1.z_in, if1.zlow_out, if1.pc_in, if1.read,
                if1.mdr_in, if1.mdr_out, if1.ir_in, if1.gra, if1.rout, if1.y_in, if1.c_out};
      r.alu = if1.alu_op; r.con = if1.con_q; r.busy = if1.busy; r.pc_in = if1.pc_in;
      r.done = if1.done; r.ill = if1.illegal; r.to = if1.timeout;
    end
    return r;
  endfunction

  function automatic logic [2:0] kcode(input kind_t k);
    case (k)
      K_DONE:  return 3'b100;
      K_ILL:   return 3'b010;
      K_TO:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Transaction-level model: outcome and cycle count from the branch rules.
  task automatic run_txn(input int s, input logic [31:0] irv, input logic [31:0] busv,
                         input int d, input bit hold, input int clr_at);
    exp_t e;
    int   wl;
    int   L;
    logic taken;
    wl = (s == 1) ? WL1 : WL0;
    case (irv[20:19])
      2'd0:    taken = (busv == 0);
      2'd1:    taken = (busv != 0);
      2'd2:    taken = ($signed(busv) >= 0);
      default: taken = ($signed(busv) < 0);
    endcase
    e.sel = s; e.pc = 1'b0; e.alu = 0;
    if (d >= wl) begin
      e.kind = K_TO; e.lat = 1 + wl; e.pc = 1'b1;   // still fetching: pc_in asserted
    end else if (irv[31:27] != BR) begin
      e.kind = K_ILL; e.lat = 4 + d;
    end else begin
      con_m[s] = taken;
      e.kind = K_DONE;
      if (s == 1 && !taken) e.lat = 4 + d;
      else begin e.lat = 7 + d; e.pc = taken; e.alu = 1; end
    end
    e.con = con_m[s];
    L = e.lat;
    if (clr_at >= L) clr_at = L - 1;
    if (clr_at > 0) begin
      e.kind = K_ABORT; con_m[0] = 1'b0; con_m[1] = 1'b0; e.con = 1'b0;
    end
    q.push_back(e);

    @(negedge clk);
    sel = s; start = 1'b1;
    ir = $urandom; bus = $urandom; mem_ready = 1'($urandom_range(0, 1));
    for (int c = 1; c <= L; c++) begin
      @(negedge clk);
      if (c == clr_at) begin
        clr = 1'b1; start = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        break;
      end
      start     = hold;
      mem_ready = (c == 1) ? 1'($urandom_range(0, 1)) : (c >= 2 + d);
      ir        = (c == 4 + d) ? irv  : $urandom;
      bus       = (c == 4 + d) ? busv : $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: pops one expectation per terminating pulse or per reset release.
  initial begin : monitor
    snap_t s;
    exp_t  e, last;
    bit    busy_p, clr_p, post;
    int    cnt, alu;
    busy_p = 0; clr_p = 0; post = 0; cnt = 0; alu = 0;
    forever begin
      @(negedge clk);
      #2;
      if (post) begin
        s = get(last.sel);
        chk("busy_after_end", {31'b0, s.busy}, 32'd0);
        chk("con_q_after_end", {31'b0, s.con}, {31'b0, last.con});
        post = 0;
      end
      s = get(sel);
      if (clr_p && !clr) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL clr_release: got reset with empty queue expected pending abort");
        end else begin
          e = q.pop_front();
          chk("clr_kind", int'(e.kind), int'(K_ABORT));
        end
        chk("clr_strobes", {18'b0, s.strb}, 32'd0);
        chk("clr_busy", {31'b0, s.busy}, 32'd0);
        chk("clr_con_q", {31'b0, s.con}, 32'd0);
        chk("clr_alu_pulses", {24'b0, s.alu, s.done, s.ill, s.to}, 32'd0);
      end
      clr_p = clr;
      if (clr) begin
        busy_p = 0;
        continue;
      end
      if (s.busy && !busy_p) begin
        cnt = 1; alu = 0;
        chk("t0_strobes", {18'b0, s.strb}, 32'h3C00);
      end else if (s.busy) cnt++;
      if (s.alu == ADD) alu++;
      else if (s.alu != 5'b0) alu += 100;
      busy_p = s.busy;
      if (s.done || s.ill || s.to) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got %b expected none", {s.done, s.ill, s.to});
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {29'b0, s.done, s.ill, s.to}, {29'b0, kcode(e.kind)});
          chk("latency", cnt, e.lat);
          chk("pc_in_at_end", {31'b0, s.pc_in}, {31'b0, e.pc});
          chk("alu_add_cycles", alu, e.alu);
          last = e;
          post = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    pool[0] = 32'h0;        pool[1] = 32'h1;        pool[2] = 32'h8000_0000;
    pool[3] = 32'hFFFF_FFFF; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
    con_m[0] = 1'b0; con_m[1] = 1'b0;
    // power-on reset
    e_reset();
    // directed cases
    run_txn(0, 32'h9B000019, 32'h0,         0, 0, 0);   // brzr taken
    run_txn(0, 32'h9B000019, 32'h5,         0, 1, 0);   // brzr not taken, start held
    run_txn(1, 32'h9B000019, 32'h5,         0, 0, 0);   // early exit
    run_txn(0, 32'h9B080019, 32'h1,         0, 0, 0);   // brnz taken
    run_txn(0, 32'h9B180019, 32'h8000_0000, 0, 0, 0);   // brmi taken
    run_txn(0, 32'h9B100019, 32'h0,         0, 0, 0);   // brpl zero taken
    run_txn(0, 32'h9B100019, 32'hFFFF_FFFF, 0, 0, 0);   // brpl negative not taken
    run_txn(0, 32'h9B000019, 32'h0,        20, 0, 0);   // timeout
    run_txn(0, 32'h9B000019, 32'h0,         2, 0, 0);   // ready on 3rd T1 cycle
    run_txn(0, 32'h2B000019, 32'h0,         0, 0, 0);   // illegal opcode
    run_txn(1, 32'h9B180019, 32'h8000_0000, 3, 0, 0);   // last wait cycle ok
    run_txn(1, 32'h9B180019, 32'h8000_0000, 4, 0, 0);   // first timeout
    run_txn(0, 32'h9B000019, 32'h0,         0, 0, 6);   // clr in T5
    run_txn(0, 32'h9B000019, 32'h0,         0, 0, 0);   // restart
    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int s, d, k, ca, wl;
      logic [31:0] irv, bv;
      s   = $urandom_range(0, 1);
      wl  = (s == 1) ? WL1 : WL0;
      irv = $urandom;
      if ($urandom_range(0, 5) != 0) irv[31:27] = BR;
      k   = $urandom_range(0, 7);
      bv  = (k < 6) ? pool[k] : $urandom;
      k   = $urandom_range(0, 9);
      if (k < 6)       d = $urandom_range(0, 3);
      else if (k == 6) d = wl - 1;
      else if (k == 7) d = wl;
      else             d = $urandom_range(0, wl + 2);
      ca  = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 8) : 0;
      run_txn(s, irv, bv, d, 1'($urandom_range(0, 1)), ca);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic e_reset();
    exp_t e;
    e.kind = K_ABORT; e.lat = 0; e.pc = 1'b0; e.alu = 0; e.con = 1'b0; e.sel = 0;
    q.push_back(e);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    idle(2);
  endtask

endmodule
